// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and reset sequencer: synchronizes raw lock, requires a stable
// lock window before releasing the design reset, and filters short lock drops in RUN.
module pll_reset_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned DROP_FILTER = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       lock,
    input  logic       restart,
    output logic       reset,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic [1:0] state
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int DROP_W = $clog2(DROP_FILTER + 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_LOST = 2'd3
    } state_t;

    state_t                 st;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;
    logic [HOLD_W-1:0]      hold_cnt;
    logic [DROP_W-1:0]      drop_cnt;

    // Raw lock is only ever seen by the first flop of this chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync[SYNC_STAGES-1];
    assign state  = st;

    // reset/ready are assigned alongside every state change so they track the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st         <= ST_WAIT;
            hold_cnt   <= '0;
            drop_cnt   <= '0;
            loss_count <= '0;
            reset      <= 1'b1;
            ready      <= 1'b0;
        end else if (restart) begin
            st       <= ST_WAIT;
            hold_cnt <= '0;
            drop_cnt <= '0;
            reset    <= 1'b1;
            ready    <= 1'b0;
        end else begin
            case (st)
                ST_WAIT: begin
                    reset <= 1'b1;
                    ready <= 1'b0;
                    if (lock_s) begin
                        st       <= ST_HOLD;
                        hold_cnt <= HOLD_W'(1);
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        st       <= ST_WAIT;
                        hold_cnt <= '0;
                        reset    <= 1'b1;
                        ready    <= 1'b0;
                    end else if (hold_cnt + HOLD_W'(1) == HOLD_W'(HOLD_CYCLES)) begin
                        st       <= ST_RUN;
                        hold_cnt <= HOLD_W'(HOLD_CYCLES);
                        drop_cnt <= '0;
                        reset    <= 1'b0;
                        ready    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        reset    <= 1'b1;
                        ready    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (lock_s) begin
                        drop_cnt <= '0;
                        reset    <= 1'b0;
                        ready    <= 1'b1;
                    end else if (drop_cnt + DROP_W'(1) == DROP_W'(DROP_FILTER)) begin
                        st       <= ST_LOST;
                        drop_cnt <= '0;
                        reset    <= 1'b1;
                        ready    <= 1'b0;
                        if (loss_count != 8'hFF) begin
                            loss_count <= loss_count + 8'd1;
                        end
                    end else begin
                        drop_cnt <= drop_cnt + DROP_W'(1);
                        reset    <= 1'b0;
                        ready    <= 1'b1;
                    end
                end
                ST_LOST: begin
                    st       <= ST_WAIT;
                    hold_cnt <= '0;
                    drop_cnt <= '0;
                    reset    <= 1'b1;
                    ready    <= 1'b0;
                end
                default: begin
                    st       <= ST_WAIT;
                    hold_cnt <= '0;
                    drop_cnt <= '0;
                    reset    <= 1'b1;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule
